// File: rtl/shadow_stack_pkg.sv
// -----------------------------------------------------------------------------
// shadow_stack_pkg
// Shared definitions for the shadow flag stack on the RAT interrupt path.
//   FLAG_C_BIT / FLAG_Z_BIT : bit positions of carry and zero in a flag word.
//   stack_op_t              : operation decoded from {FLG_SHAD_LD, FLG_SHAD_RESTORE}.
//   decode_op()             : request pair -> stack_op_t.
//   next_ptr()              : modulo-depth pointer step, valid for any depth >= 1.
// -----------------------------------------------------------------------------
package shadow_stack_pkg;

    localparam int FLAG_C_BIT = 0;
    localparam int FLAG_Z_BIT = 1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic ld, input logic restore);
        stack_op_t op;
        case ({ld, restore})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

    // Explicit compare-and-wrap rather than a bit mask so that
    // non-power-of-2 depths wrap correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input logic        inc,
                                             input int unsigned depth);
        int unsigned res;
        if (inc) begin
            res = (ptr >= depth - 1) ? 0 : ptr + 1;
        end else begin
            res = (ptr == 0) ? depth - 1 : ptr - 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/shadow_flag_stack.sv
// -----------------------------------------------------------------------------
// shadow_flag_stack
// LIFO of flag words replacing the single-entry shadow Z/C registers so that
// interrupts can nest. Push on interrupt entry, pop on RETIE/RETID.
//
// Build option: define SHADOW_STACK_WRAP_EN to make a push while full
// overwrite the oldest entry; otherwise such a push is dropped. OVERFLOW is
// set in both builds.
//
// Parameters:
//   FLAG_W  flag word width (bit 0 = C, bit 1 = Z, rest reserved)
//   DEPTH   number of nesting levels, >= 2
// Ports:
//   clk               system clock, rising edge
//   RST_N             asynchronous active-low reset
//   FLAGS_IN          live flags to save
//   FLG_SHAD_LD       push request
//   FLG_SHAD_RESTORE  pop request (both together = replace top)
//   CLR_ERR           clear sticky OVERFLOW/UNDERFLOW (a new error wins)
//   SHAD_FLAGS        top-of-stack entry, 0 when empty
//   LEVEL             number of valid entries
//   EMPTY / FULL      LEVEL == 0 / LEVEL == DEPTH
//   OVERFLOW          sticky: push while full
//   UNDERFLOW         sticky: pop (or replace) while empty
// -----------------------------------------------------------------------------
module shadow_flag_stack
    import shadow_stack_pkg::*;
#(
    parameter int FLAG_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       RST_N,
    input  logic [FLAG_W-1:0]          FLAGS_IN,
    input  logic                       FLG_SHAD_LD,
    input  logic                       FLG_SHAD_RESTORE,
    input  logic                       CLR_ERR,
    output logic [FLAG_W-1:0]          SHAD_FLAGS,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [FLAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top;
    logic [LVL_W-1:0]  level;
    logic              ovf;
    logic              udf;

    stack_op_t         op;
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;
    logic [PTR_W-1:0]  top_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [PTR_W-1:0]  waddr;
    logic              mem_we;
    logic              ovf_set;
    logic              udf_set;
    logic              empty;
    logic              full;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign op      = decode_op(FLG_SHAD_LD, FLG_SHAD_RESTORE);
    assign top_inc = PTR_W'(next_ptr(32'(top), 1'b1, DEPTH));
    assign top_dec = PTR_W'(next_ptr(32'(top), 1'b0, DEPTH));

    always_comb begin
        top_nxt   = top;
        level_nxt = level;
        waddr     = top_inc;
        mem_we    = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    top_nxt   = top_inc;
                    level_nxt = level + LVL_W'(1);
                    mem_we    = 1'b1;
                end else begin
                    ovf_set = 1'b1;
`ifdef SHADOW_STACK_WRAP_EN
                    // Slot after top is the oldest entry when full.
                    top_nxt = top_inc;
                    mem_we  = 1'b1;
`endif
                end
            end
            OP_POP: begin
                if (!empty) begin
                    top_nxt   = top_dec;
                    level_nxt = level - LVL_W'(1);
                end else begin
                    udf_set = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (!empty) begin
                    waddr  = top;
                    mem_we = 1'b1;
                end else begin
                    // Pop half is illegal on an empty stack; the push half still lands.
                    top_nxt   = top_inc;
                    level_nxt = LVL_W'(1);
                    mem_we    = 1'b1;
                    udf_set   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            top   <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            top   <= top_nxt;
            level <= level_nxt;
            ovf   <= ovf_set | (ovf & ~CLR_ERR);
            udf   <= udf_set | (udf & ~CLR_ERR);
        end
    end

    // Storage needs no reset: entries are only visible while counted by level.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr] <= FLAGS_IN;
        end
    end

    assign SHAD_FLAGS = empty ? '0 : mem[top];
    assign LEVEL      = level;
    assign EMPTY      = empty;
    assign FULL       = full;
    assign OVERFLOW   = ovf;
    assign UNDERFLOW  = udf;

endmodule

// File: tb/tb_shadow_flag_stack.sv
module tb_shadow_flag_stack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld, rs, clr;
    logic [1:0] fin;

    logic [1:0] shad4, shad3;
    logic [2:0] lvl4;
    logic [1:0] lvl3;
    logic       emp4, ful4, ovf4, udf4;
    logic       emp3, ful3, ovf3, udf3;

    always #5 clk = ~clk;

    shadow_flag_stack #(.FLAG_W(2), .DEPTH(4)) u_d4 (
        .clk(clk), .RST_N(rst_n), .FLAGS_IN(fin), .FLG_SHAD_LD(ld),
        .FLG_SHAD_RESTORE(rs), .CLR_ERR(clr), .SHAD_FLAGS(shad4),
        .LEVEL(lvl4), .EMPTY(emp4), .FULL(ful4), .OVERFLOW(ovf4), .UNDERFLOW(udf4)
    );

    shadow_flag_stack #(.FLAG_W(2), .DEPTH(3)) u_d3 (
        .clk(clk), .RST_N(rst_n), .FLAGS_IN(fin), .FLG_SHAD_LD(ld),
        .FLG_SHAD_RESTORE(rs), .CLR_ERR(clr), .SHAD_FLAGS(shad3),
        .LEVEL(lvl3), .EMPTY(emp3), .FULL(ful3), .OVERFLOW(ovf3), .UNDERFLOW(udf3)
    );

`ifdef SHADOW_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = DEPTH 4, index 1 = DEPTH 3; queue back = top.
    logic [1:0] mq [2][$];
    bit         m_ovf [2];
    bit         m_udf [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic l, input logic r, input logic [1:0] f, input logic c);
        for (int k = 0; k < 2; k++) begin
            int  depth;
            bit  os, us;
            depth = (k == 0) ? 4 : 3;
            os = 1'b0;
            us = 1'b0;
            if (l && !r) begin
                if (mq[k].size() == depth) begin
                    os = 1'b1;
                    if (WRAP) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(f);
                    end
                end else begin
                    mq[k].push_back(f);
                end
            end else if (!l && r) begin
                if (mq[k].size() == 0) us = 1'b1;
                else void'(mq[k].pop_back());
            end else if (l && r) begin
                if (mq[k].size() == 0) begin
                    mq[k].push_back(f);
                    us = 1'b1;
                end else begin
                    mq[k][mq[k].size()-1] = f;
                end
            end
            m_ovf[k] = os | (m_ovf[k] & !c);
            m_udf[k] = us | (m_udf[k] & !c);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            int         depth, sz;
            logic [1:0] es;
            logic [1:0] os;
            logic [2:0] ol;
            logic       oe, of, oo, ou;
            depth = (k == 0) ? 4 : 3;
            sz    = mq[k].size();
            es    = (sz == 0) ? 2'b00 : mq[k][sz-1];
            if (k == 0) begin
                os = shad4; ol = lvl4; oe = emp4; of = ful4; oo = ovf4; ou = udf4;
            end else begin
                os = shad3; ol = {1'b0, lvl3}; oe = emp3; of = ful3; oo = ovf3; ou = udf3;
            end
            chk($sformatf("%s_d%0d_shad", tag, depth), 8'(os), 8'(es));
            chk($sformatf("%s_d%0d_level", tag, depth), 8'(ol), 8'(sz));
            chk($sformatf("%s_d%0d_empty", tag, depth), 8'(oe), 8'(sz == 0));
            chk($sformatf("%s_d%0d_full", tag, depth), 8'(of), 8'(sz == depth));
            chk($sformatf("%s_d%0d_ovf", tag, depth), 8'(oo), 8'(m_ovf[k]));
            chk($sformatf("%s_d%0d_udf", tag, depth), 8'(ou), 8'(m_udf[k]));
        end
    endtask

    task automatic step(input logic l, input logic r, input logic [1:0] f,
                        input logic c, input string tag);
        ld  = l;
        rs  = r;
        fin = f;
        clr = c;
        @(posedge clk);
        #1;
        model_step(l, r, f, c);
        check_all(tag);
        ld  = 1'b0;
        rs  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ld = 1'b0; rs = 1'b0; clr = 1'b0; fin = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_shad_const", 8'(shad4), 8'h00);
        chk("reset_empty_const", 8'(emp4), 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nested push/pop
        step(1, 0, 2'd1, 0, "nest_push1");
        step(1, 0, 2'd2, 0, "nest_push2");
        step(1, 0, 2'd3, 0, "nest_push3");
        chk("nest_top", 8'(shad4), 8'd3);
        chk("nest_level", 8'(lvl4), 8'd3);
        step(0, 1, 2'd0, 0, "nest_pop1");
        chk("nest_pop1_val", 8'(shad4), 8'd2);
        step(0, 1, 2'd0, 0, "nest_pop2");
        chk("nest_pop2_val", 8'(shad4), 8'd1);
        step(0, 1, 2'd0, 0, "nest_pop3");
        chk("nest_pop3_val", 8'(shad4), 8'd0);
        chk("nest_empty", 8'(emp4), 8'd1);

        // Overflow
        for (int i = 0; i < 4; i++) step(1, 0, 2'(i), 0, "ovf_fill");
        step(1, 0, 2'd0, 0, "ovf_push");
        chk("ovf_flag", 8'(ovf4), 8'd1);
        chk("ovf_level", 8'(lvl4), 8'd4);
        chk("ovf_top", 8'(shad4), WRAP ? 8'd0 : 8'd3);
        begin
            logic [1:0] seq_nw [4];
            logic [1:0] seq_w  [4];
            seq_nw = '{2'd3, 2'd2, 2'd1, 2'd0};
            seq_w  = '{2'd0, 2'd3, 2'd2, 2'd1};
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovf_popseq%0d", i), 8'(shad4), WRAP ? 8'(seq_w[i]) : 8'(seq_nw[i]));
                step(0, 1, 2'd0, 0, "ovf_pop");
            end
        end
        chk("ovf_drained", 8'(emp4), 8'd1);
        step(0, 0, 2'd0, 1, "ovf_clr");
        chk("ovf_cleared", 8'(ovf4), 8'd0);

        // Underflow and clear priority
        step(0, 1, 2'd0, 0, "udf_pop");
        chk("udf_flag", 8'(udf4), 8'd1);
        chk("udf_level", 8'(lvl4), 8'd0);
        step(0, 1, 2'd0, 1, "udf_pop_clr");
        chk("udf_set_wins", 8'(udf4), 8'd1);
        step(0, 0, 2'd0, 1, "udf_clr");
        chk("udf_cleared", 8'(udf4), 8'd0);

        // Simultaneous LD + RESTORE
        step(1, 0, 2'd2, 0, "rep_push_a");
        step(1, 0, 2'd1, 0, "rep_push_b");
        step(1, 1, 2'd3, 0, "rep_replace");
        chk("rep_level", 8'(lvl4), 8'd2);
        chk("rep_top", 8'(shad4), 8'd3);
        step(0, 1, 2'd0, 0, "rep_pop");
        chk("rep_below", 8'(shad4), 8'd2);
        step(0, 1, 2'd0, 0, "rep_drain");
        step(1, 1, 2'd2, 0, "rep_empty");
        chk("rep_empty_level", 8'(lvl4), 8'd1);
        chk("rep_empty_top", 8'(shad4), 8'd2);
        chk("rep_empty_udf", 8'(udf4), 8'd1);
        step(0, 1, 2'd0, 1, "rep_cleanup");

        // Asynchronous reset mid-operation
        step(0, 1, 2'd0, 0, "ar_udf");
        step(1, 0, 2'b01, 0, "ar_push1");
        step(1, 0, 2'b10, 0, "ar_push2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_level", 8'(lvl4), 8'd0);
        chk("async_rst_shad", 8'(shad4), 8'd0);
        chk("async_rst_udf", 8'(udf4), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst");

        // Random ops; DEPTH 3 instance exercises non-power-of-2 wrap
        for (int i = 0; i < 60; i++) begin
            logic [1:0] o;
            logic       c;
            o = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 7) == 0);
            step(o[1], o[0], 2'($urandom), c, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shadow_flag_stack.md
Name: shadow_flag_stack

Overview:
- Parametrised shadow-flag storage for the RAT interrupt path. It replaces the single-entry shadow Z/C registers with a LIFO stack of flag words, so interrupts can nest.
- Push (FLG_SHAD_LD) saves the live flags on interrupt entry. Pop (FLG_SHAD_RESTORE) restores them on RETIE/RETID.
- Sits beside the flag registers and is driven by the control unit FSM. The SHAD_FLAGS output feeds the flag-register restore muxes.

Parameters:
- FLAG_W, 2, flag word width; bit 0 = C, bit 1 = Z, higher bits reserved for future flags.
- DEPTH, 4, number of stacked entries (nesting levels); must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- FLAGS_IN  input  FLAG_W  live flag word to save.
- FLG_SHAD_LD  input  1  push request (interrupt entry).
- FLG_SHAD_RESTORE  input  1  pop request (interrupt return).
- CLR_ERR  input  1  synchronous clear of sticky error flags.
- SHAD_FLAGS  output  FLAG_W  top-of-stack entry; 0 when empty.
- LEVEL  output  $clog2(DEPTH+1)  number of valid entries.
- EMPTY  output  1  LEVEL == 0.
- FULL  output  1  LEVEL == DEPTH.
- OVERFLOW  output  1  sticky: a push occurred while FULL.
- UNDERFLOW  output  1  sticky: a pop occurred while EMPTY.

Behaviour:
- Reset (RST_N low, asynchronous):
  - LEVEL = 0, EMPTY = 1, FULL = 0.
  - OVERFLOW = 0, UNDERFLOW = 0, SHAD_FLAGS = 0.
  - Storage contents are don't-care.
  - Release is synchronous to clk via the normal flop path; no operation executes on the edge where RST_N is low.
- Storage is a circular buffer: DEPTH × FLAG_W registers, a top pointer TOP, and LEVEL. No RAM inference.
- SHAD_FLAGS = mem[TOP] when LEVEL > 0, else 0. It is driven combinationally from registers, with no combinational path from the inputs.
- Latency is 1 cycle: the effect of a request sampled at edge N is visible on every output after edge N.
- Operations per edge, decoded as {LD, RESTORE}:
  - 00: hold.
  - 10, not FULL: TOP ← TOP+1 mod DEPTH; mem[new TOP] ← FLAGS_IN; LEVEL+1.
  - 10, FULL: see Optional Feature. OVERFLOW ← 1 in both builds.
  - 01, not EMPTY: TOP ← TOP−1 mod DEPTH; LEVEL−1.
  - 01, EMPTY: state unchanged; UNDERFLOW ← 1.
  - 11, not EMPTY: replace top, i.e. mem[TOP] ← FLAGS_IN with LEVEL unchanged. This covers a return immediately followed by a re-entry in the same cycle.
  - 11, EMPTY: behaves as a push (LEVEL → 1); UNDERFLOW ← 1.
- Pointer arithmetic wraps modulo DEPTH, and must be correct for non-power-of-2 DEPTH.
- CLR_ERR clears OVERFLOW and UNDERFLOW on the next edge. If an error event occurs in the same cycle as CLR_ERR, the set wins.
- FULL and EMPTY are derived from LEVEL and are never registered separately.

Optional Feature:
- Macro: SHADOW_STACK_WRAP_EN.
- Defined: a push while FULL overwrites the oldest entry.
  - TOP advances and mem[new TOP] ← FLAGS_IN; LEVEL stays at DEPTH.
  - The newest flags are always preserved.
- Undefined: a push while FULL is dropped. TOP, LEVEL and mem are unchanged; SHAD_FLAGS still shows the previous top.
- In both builds, OVERFLOW is set on a push while FULL.

Decomposition:
- Package shadow_stack_pkg holds:
  - localparams FLAG_C_BIT = 0 and FLAG_Z_BIT = 1;
  - typedef enum logic [1:0] stack_op_t {OP_HOLD, OP_PUSH, OP_POP, OP_REPLACE}, decoded from {LD, RESTORE};
  - a function next_ptr(ptr, inc/dec, depth) implementing the modulo wrap.
- No sub-module; the storage array and control logic fit in one module.

Test Plan:
- Reset mid-operation: push 2'b01 and 2'b10, then assert RST_N low asynchronously between edges. Required: LEVEL = 0, EMPTY = 1 and SHAD_FLAGS = 0 immediately; errors cleared.
- Nested push/pop with DEPTH = 4: push 1, 2, 3. Required: SHAD_FLAGS = 3 and LEVEL = 3. Pop three times; SHAD_FLAGS must read 2, 1, 0 and EMPTY must be 1 at the end.
- Overflow with DEPTH = 4: push 0, 1, 2, 3, then push 2'b00 again. Required:
  - without the macro: SHAD_FLAGS = 3, OVERFLOW = 1, LEVEL = 4, and popping four times yields 3, 2, 1, 0;
  - with SHADOW_STACK_WRAP_EN: SHAD_FLAGS = 0, and popping four times yields 0, 3, 2, 1.
- Underflow: pop when EMPTY. Required: UNDERFLOW = 1 and LEVEL = 0. Then assert CLR_ERR together with another pop-while-empty; UNDERFLOW must stay 1. CLR_ERR alone then clears it to 0.
- Simultaneous LD + RESTORE:
  - with LEVEL = 2 and top = 1, FLAGS_IN = 2'b11: required LEVEL = 2, SHAD_FLAGS = 3, and the entry below (a pop) is unchanged;
  - when EMPTY: required LEVEL = 1, SHAD_FLAGS = FLAGS_IN, UNDERFLOW = 1.
- Non-power-of-2 DEPTH = 3: perform 10 random push/pop operations against a queue-based reference model. Required: SHAD_FLAGS and LEVEL match the model every cycle, including across pointer wrap-around.
